// File: rtl/dhcp_client_fsm.sv
// DHCP client control stage: sequences DISCOVER/REQUEST through the TX
// handshake, runs the retry and lease/T1/T2 timers and publishes the lease.
//
// TX handshake: tx_req rises together with tx_type/tx_broadcast/req_ipaddr/
// req_serverid and all of them hold until the cycle tx_ack=1 is sampled.
// tx_req then drops and tx_type returns to 00. tx_ack with tx_req=0 is
// ignored. While a message is pending, parser strobes are dropped and no
// timer counts.
module dhcp_client_fsm #(
  parameter int unsigned CLKS_PER_SEC = 125000000,
  parameter int unsigned RETRY_SEC    = 4,
  parameter int unsigned MAX_RETRY    = 3,
  parameter int unsigned MIN_LEASE    = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        enable,
  input  logic        dhcpoffer,
  input  logic        dhcpacknowledge,
  input  logic [31:0] YIAddr,
  input  logic [31:0] SIAddr,
  input  logic [31:0] ipleasetime,
  output logic        tx_req,
  output logic [1:0]  tx_type,
  output logic        tx_broadcast,
  output logic [31:0] req_ipaddr,
  output logic [31:0] req_serverid,
  input  logic        tx_ack,
  output logic        bound,
  output logic [31:0] my_ipaddr,
  output logic [31:0] lease_remaining,
  output logic [2:0]  state_out,
  output logic        fail
);

  typedef enum logic [2:0] {
    S_INIT       = 3'd0,
    S_SELECTING  = 3'd1,
    S_REQUESTING = 3'd2,
    S_BOUND      = 3'd3,
    S_RENEWING   = 3'd4,
    S_REBINDING  = 3'd5
  } state_t;

  localparam logic [1:0] TX_NONE     = 2'b00;
  localparam logic [1:0] TX_DISCOVER = 2'b01;
  localparam logic [1:0] TX_REQUEST  = 2'b11;

  localparam int          PW         = $clog2(CLKS_PER_SEC);
  localparam logic [PW-1:0] PRESC_MAX = PW'(CLKS_PER_SEC - 1);
  localparam logic [31:0] RETRY_LOAD = 32'(RETRY_SEC);
  localparam logic [31:0] RETRY_MAX  = 32'(MAX_RETRY);
  localparam logic [31:0] LEASE_MIN  = 32'(MIN_LEASE);

  state_t        state_q;
  logic [PW-1:0] presc_q;
  logic          sec_tick;
  logic          tx_req_q, tx_bcast_q, bound_q, fail_q, inf_q;
  logic [1:0]    tx_type_q;
  logic [31:0]   req_ip_q, req_sid_q, my_ip_q;
  logic [31:0]   offered_q, server_q;
  logic [31:0]   retry_q, retry_cnt_q;
  logic [31:0]   lease_q, t1_q, t2_q, elapsed_q;
  logic [31:0]   lease_d, t1_d, t2_d, elapsed_d;
  logic          inf_d;

  assign sec_tick = (presc_q == PRESC_MAX);

  // Lease values derived from the parser fields on an ACK, and the next elapsed count.
  always_comb begin
    lease_d   = (ipleasetime < LEASE_MIN) ? LEASE_MIN : ipleasetime;
    t1_d      = lease_d >> 1;
    t2_d      = lease_d - (lease_d >> 3);
    inf_d     = (ipleasetime == 32'hFFFF_FFFF);
    elapsed_d = elapsed_q + 32'd1;
  end

  // Free-running one-second prescaler; runs in every state.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)         presc_q <= '0;
    else if (sec_tick) presc_q <= '0;
    else               presc_q <= presc_q + PW'(1);
  end

  // Client state machine with all TX and lease outputs registered.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= S_INIT;
      tx_req_q    <= 1'b0;
      tx_type_q   <= TX_NONE;
      tx_bcast_q  <= 1'b0;
      req_ip_q    <= '0;
      req_sid_q   <= '0;
      bound_q     <= 1'b0;
      my_ip_q     <= '0;
      fail_q      <= 1'b0;
      offered_q   <= '0;
      server_q    <= '0;
      retry_q     <= '0;
      retry_cnt_q <= '0;
      lease_q     <= '0;
      t1_q        <= '0;
      t2_q        <= '0;
      inf_q       <= 1'b0;
      elapsed_q   <= '0;
    end else begin
      fail_q <= 1'b0;
      if (!enable) begin
        // Abandon everything, including a pending message, without a fail pulse.
        state_q     <= S_INIT;
        tx_req_q    <= 1'b0;
        tx_type_q   <= TX_NONE;
        tx_bcast_q  <= 1'b0;
        req_ip_q    <= '0;
        req_sid_q   <= '0;
        bound_q     <= 1'b0;
        my_ip_q     <= '0;
        retry_q     <= '0;
        retry_cnt_q <= '0;
        lease_q     <= '0;
        t1_q        <= '0;
        t2_q        <= '0;
        inf_q       <= 1'b0;
        elapsed_q   <= '0;
      end else if (tx_req_q) begin
        if (tx_ack) begin
          tx_req_q  <= 1'b0;
          tx_type_q <= TX_NONE;
          retry_q   <= RETRY_LOAD;
          if (state_q == S_INIT) state_q <= S_SELECTING;
        end
      end else begin
        if (sec_tick && (retry_q != '0)) retry_q <= retry_q - 32'd1;
        case (state_q)
          S_INIT: begin
            tx_req_q   <= 1'b1;
            tx_type_q  <= TX_DISCOVER;
            tx_bcast_q <= 1'b1;
            req_ip_q   <= '0;
            req_sid_q  <= '0;
          end
          S_SELECTING: begin
            if (dhcpoffer) begin
              offered_q   <= YIAddr;
              server_q    <= SIAddr;
              retry_cnt_q <= '0;
              state_q     <= S_REQUESTING;
              tx_req_q    <= 1'b1;
              tx_type_q   <= TX_REQUEST;
              tx_bcast_q  <= 1'b1;
              req_ip_q    <= YIAddr;
              req_sid_q   <= SIAddr;
            end else if (retry_q == '0) begin
              tx_req_q   <= 1'b1;
              tx_type_q  <= TX_DISCOVER;
              tx_bcast_q <= 1'b1;
              req_ip_q   <= '0;
              req_sid_q  <= '0;
            end
          end
          S_REQUESTING: begin
            if (dhcpacknowledge) begin
              lease_q   <= lease_d;
              t1_q      <= t1_d;
              t2_q      <= t2_d;
              inf_q     <= inf_d;
              elapsed_q <= '0;
              my_ip_q   <= offered_q;
              bound_q   <= 1'b1;
              state_q   <= S_BOUND;
            end else if (retry_q == '0) begin
              if (retry_cnt_q < RETRY_MAX) begin
                retry_cnt_q <= retry_cnt_q + 32'd1;
                tx_req_q    <= 1'b1;
                tx_type_q   <= TX_REQUEST;
                tx_bcast_q  <= 1'b1;
                req_ip_q    <= offered_q;
                req_sid_q   <= server_q;
              end else begin
                fail_q  <= 1'b1;
                state_q <= S_INIT;
              end
            end
          end
          S_BOUND: begin
            // Thresholds are tested against the value elapsed is about to take.
            if (sec_tick && !inf_q) begin
              elapsed_q <= elapsed_d;
              if (elapsed_d >= t1_q) begin
                state_q    <= S_RENEWING;
                tx_req_q   <= 1'b1;
                tx_type_q  <= TX_REQUEST;
                tx_bcast_q <= 1'b0;
                req_ip_q   <= my_ip_q;
                req_sid_q  <= server_q;
              end
            end
          end
          S_RENEWING, S_REBINDING: begin
            if (dhcpacknowledge) begin
              lease_q   <= lease_d;
              t1_q      <= t1_d;
              t2_q      <= t2_d;
              inf_q     <= inf_d;
              elapsed_q <= '0;
              state_q   <= S_BOUND;
            end else if (sec_tick && !inf_q) begin
              if ((state_q == S_REBINDING) && (elapsed_d >= lease_q)) begin
                bound_q   <= 1'b0;
                my_ip_q   <= '0;
                lease_q   <= '0;
                elapsed_q <= '0;
                state_q   <= S_INIT;
              end else begin
                elapsed_q <= elapsed_d;
                if ((state_q == S_RENEWING) && (elapsed_d >= t2_q)) begin
                  state_q    <= S_REBINDING;
                  tx_req_q   <= 1'b1;
                  tx_type_q  <= TX_REQUEST;
                  tx_bcast_q <= 1'b1;
                  req_ip_q   <= my_ip_q;
                  req_sid_q  <= server_q;
                end
              end
            end
          end
          default: state_q <= S_INIT;
        endcase
      end
    end
  end

  assign tx_req          = tx_req_q;
  assign tx_type         = tx_type_q;
  assign tx_broadcast    = tx_bcast_q;
  assign req_ipaddr      = req_ip_q;
  assign req_serverid    = req_sid_q;
  assign bound           = bound_q;
  assign my_ipaddr       = my_ip_q;
  assign lease_remaining = bound_q ? (lease_q - elapsed_q) : 32'd0;
  assign state_out       = state_q;
  assign fail            = fail_q;

endmodule

// File: tb/tb_dhcp_client_fsm.sv
// Bench for dhcp_client_fsm with a 4-cycle second and a 2-second retry.
module tb_dhcp_client_fsm;

  localparam logic [31:0] IP1 = 32'hC0A8010A;
  localparam logic [31:0] SRV = 32'hC0A80101;
  localparam logic [31:0] IP2 = 32'hC0A80120;
  localparam logic [31:0] IP3 = 32'hC0A80130;

  logic        clock = 1'b0;
  logic        reset, enable, dhcpoffer, dhcpacknowledge, tx_ack;
  logic [31:0] YIAddr, SIAddr, ipleasetime;
  logic        tx_req, tx_broadcast, bound, fail;
  logic [1:0]  tx_type;
  logic [31:0] req_ipaddr, req_serverid, my_ipaddr, lease_remaining;
  logic [2:0]  state_out;

  int n_checks = 0;
  int n_errs   = 0;
  logic [69:0] exp_q[$];

  dhcp_client_fsm #(
    .CLKS_PER_SEC(4), .RETRY_SEC(2), .MAX_RETRY(3), .MIN_LEASE(8)
  ) dut (
    .clock(clock), .reset(reset), .enable(enable),
    .dhcpoffer(dhcpoffer), .dhcpacknowledge(dhcpacknowledge),
    .YIAddr(YIAddr), .SIAddr(SIAddr), .ipleasetime(ipleasetime),
    .tx_req(tx_req), .tx_type(tx_type), .tx_broadcast(tx_broadcast),
    .req_ipaddr(req_ipaddr), .req_serverid(req_serverid), .tx_ack(tx_ack),
    .bound(bound), .my_ipaddr(my_ipaddr), .lease_remaining(lease_remaining),
    .state_out(state_out), .fail(fail)
  );

  // Clock and watchdog
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  // Checking
  task automatic chk(input string tag, input logic [69:0] got, input logic [69:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [69:0] txw(input logic [2:0] st, input logic [1:0] ty,
                                       input logic bc, input logic [31:0] ip,
                                       input logic [31:0] sid);
    return {st, ty, bc, ip, sid};
  endfunction

  // Driver tasks: inputs change and outputs are sampled 1 ns after posedge
  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic push_tx(input logic [2:0] st, input logic [1:0] ty, input logic bc,
                         input logic [31:0] ip, input logic [31:0] sid);
    exp_q.push_back(txw(st, ty, bc, ip, sid));
  endtask

  task automatic wait_tx(input string tag, input int max_cyc, output int cyc);
    logic [69:0] e;
    cyc = 0;
    while (tx_req !== 1'b1 && cyc < max_cyc) begin
      step();
      cyc++;
    end
    if (tx_req !== 1'b1) chk({tag, " timeout"}, 70'd0, 70'd1);
    else if (exp_q.size() == 0) chk({tag, " unexpected"}, 70'd1, 70'd0);
    else begin
      e = exp_q.pop_front();
      chk(tag, txw(state_out, tx_type, tx_broadcast, req_ipaddr, req_serverid), e);
    end
  endtask

  task automatic ack_tx(input string tag);
    tx_ack = 1'b1;
    step();
    tx_ack = 1'b0;
    chk({tag, " req clr"}, {67'd0, tx_req, tx_type}, 70'd0);
  endtask

  task automatic offer(input logic [31:0] yi, input logic [31:0] si);
    YIAddr = yi; SIAddr = si; dhcpoffer = 1'b1;
    step();
    dhcpoffer = 1'b0;
  endtask

  task automatic ack_lease(input logic [31:0] lease);
    ipleasetime = lease; dhcpacknowledge = 1'b1;
    step();
    dhcpacknowledge = 1'b0;
  endtask

  task automatic wait_state(input string tag, input logic [2:0] st, input int max_cyc);
    int cyc;
    cyc = 0;
    while (state_out !== st && cyc < max_cyc) begin
      step();
      cyc++;
    end
    chk(tag, 70'(state_out), 70'(st));
  endtask

  // Get from INIT to SELECTING through one DISCOVER
  task automatic discover(input string tag);
    int c;
    push_tx(3'd0, 2'b01, 1'b1, 32'd0, 32'd0);
    wait_tx(tag, 10, c);
    ack_tx(tag);
    chk({tag, " selecting"}, 70'(state_out), 70'd1);
  endtask

  // Get from SELECTING to BOUND with the given address and lease
  task automatic obtain(input string tag, input logic [31:0] ip, input logic [31:0] lease);
    int c;
    push_tx(3'd2, 2'b11, 1'b1, ip, SRV);
    offer(ip, SRV);
    wait_tx({tag, " request"}, 10, c);
    ack_tx(tag);
    ack_lease(lease);
    chk({tag, " bound"}, {3'd0, state_out, bound, my_ipaddr, 32'd0},
        {3'd0, 3'd3, 1'b1, ip, 32'd0});
  endtask

  // Stimulus
  initial begin
    int c;
    logic ok;
    reset = 1'b1; enable = 1'b0; dhcpoffer = 1'b0; dhcpacknowledge = 1'b0;
    tx_ack = 1'b0; YIAddr = '0; SIAddr = '0; ipleasetime = '0;
    step(3);
    chk("reset outputs",
        {tx_req, tx_type, tx_broadcast, bound, fail, state_out, my_ipaddr, lease_remaining},
        70'd0);
    chk("reset req fields", {6'd0, req_ipaddr, req_serverid}, 70'd0);
    reset = 1'b0;
    step(3);
    chk("idle while disabled", {67'd0, tx_req, state_out == 3'd0}, 70'd1);

    // Normal flow, then renew / rebind / expire with lease 16
    enable = 1'b1;
    discover("discover1");
    obtain("flow", IP1, 32'd16);
    chk("lease16 start", 70'(lease_remaining), 70'd16);
    c = 0;
    while (lease_remaining == 32'd16 && c < 8) begin step(); c++; end
    chk("lease dec 1", 70'(lease_remaining), 70'd15);
    step(4);
    chk("lease dec 2", 70'(lease_remaining), 70'd14);
    step(4);
    chk("lease dec 3", 70'(lease_remaining), 70'd13);
    push_tx(3'd4, 2'b11, 1'b0, IP1, SRV);
    wait_tx("renew unicast", 60, c);
    chk("renew at 8", 70'(lease_remaining), 70'd8);
    ack_tx("renew");
    push_tx(3'd5, 2'b11, 1'b1, IP1, SRV);
    wait_tx("rebind bcast", 60, c);
    chk("rebind at 14", 70'(lease_remaining), 70'd2);
    ack_tx("rebind");
    wait_state("expire init", 3'd0, 30);
    chk("expire cleared", {5'd0, bound, my_ipaddr, lease_remaining}, 70'd0);
    discover("rediscover");

    // Renew success, lease clamp and infinite lease
    obtain("renew", IP2, 32'd16);
    push_tx(3'd4, 2'b11, 1'b0, IP2, SRV);
    wait_tx("renew2 req", 60, c);
    ack_tx("renew2");
    ack_lease(32'd40);
    chk("renew40 state", {3'd0, state_out, bound, 63'(lease_remaining)},
        {3'd0, 3'd3, 1'b1, 63'd40});
    push_tx(3'd4, 2'b11, 1'b0, IP2, SRV);
    wait_tx("renew40 req", 120, c);
    chk("renew at 20", 70'(lease_remaining), 70'd20);
    ack_tx("renew40");
    ack_lease(32'd3);
    chk("lease clamp", 70'(lease_remaining), 70'd8);
    push_tx(3'd4, 2'b11, 1'b0, IP2, SRV);
    wait_tx("clamp renew", 40, c);
    chk("clamp renew at 4", 70'(lease_remaining), 70'd4);
    ack_tx("clamp renew");
    ack_lease(32'hFFFF_FFFF);
    chk("inf lease", 70'(lease_remaining), 70'hFFFF_FFFF);
    step(48);
    chk("inf still bound", {3'd0, state_out, bound, tx_req, my_ipaddr, 30'd0},
        {3'd0, 3'd3, 1'b1, 1'b0, IP2, 30'd0});
    chk("inf remaining", 70'(lease_remaining), 70'hFFFF_FFFF);

    // Disable while bound, then a stray ACK in SELECTING
    enable = 1'b0;
    step();
    chk("disable bound", {3'd0, state_out, bound, tx_req, my_ipaddr, 30'd0}, 70'd0);
    enable = 1'b1;
    discover("discover3");
    ack_lease(32'd16);
    chk("stray ack", {66'd0, state_out, bound}, {66'd0, 3'd1, 1'b0});

    // Request exhaustion: four REQUESTs two seconds apart, then fail and DISCOVER
    push_tx(3'd2, 2'b11, 1'b1, IP3, SRV);
    offer(IP3, SRV);
    wait_tx("exh req0", 10, c);
    ack_tx("exh0");
    for (int i = 1; i <= 3; i++) begin
      push_tx(3'd2, 2'b11, 1'b1, IP3, SRV);
      wait_tx($sformatf("exh req%0d", i), 20, c);
      ok = (c >= 6 && c <= 9);
      chk($sformatf("exh gap%0d", i), 70'(ok), 70'd1);
      ack_tx("exh");
    end
    c = 0;
    while (fail !== 1'b1 && c < 20) begin step(); c++; end
    ok = (c >= 6 && c <= 9);
    chk("fail pulse", {66'd0, fail, state_out}, {66'd0, 1'b1, 3'd0});
    chk("fail gap", 70'(ok), 70'd1);
    push_tx(3'd0, 2'b01, 1'b1, 32'd0, 32'd0);
    step();
    chk("fail one cycle", 70'(fail), 70'd0);
    wait_tx("post-fail discover", 2, c);
    ack_tx("post-fail");

    // Disable with a REQUEST pending
    push_tx(3'd2, 2'b11, 1'b1, IP1, SRV);
    offer(IP1, SRV);
    wait_tx("pending req", 10, c);
    enable = 1'b0;
    step();
    chk("abandon pending", {64'd0, tx_req, fail, tx_type, state_out == 3'd0, bound},
        {64'd0, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0});

    // Asynchronous reset with a DISCOVER pending
    enable = 1'b1;
    push_tx(3'd0, 2'b01, 1'b1, 32'd0, 32'd0);
    wait_tx("pre-reset discover", 5, c);
    #2 reset = 1'b1;
    #1;
    chk("async reset", {66'd0, tx_req, state_out}, 70'd0);
    step();
    reset = 1'b0;
    step();
    chk("queue empty", 70'(exp_q.size()), 70'd0);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule

// File: doc/dhcp_client_fsm.md
Name: dhcp_client_fsm

Overview:
- DHCP client control stage, directly downstream of the DHCP receive parser.
- Consumes the parser's one-cycle offer/acknowledge strobes and the latched YIAddr/SIAddr/lease time.
- Sequences DISCOVER/REQUEST transmissions through a request/acknowledge handshake to the UDP transmit path, runs retry timers and the lease/T1/T2 timers, and publishes the bound IP address to the rest of the design.

Parameters:
CLKS_PER_SEC, 125000000, clock cycles per one-second tick; minimum 2.
RETRY_SEC, 4, seconds to wait for OFFER/ACK after a message is accepted by TX.
MAX_RETRY, 3, REQUEST retransmissions in REQUESTING before giving up.
MIN_LEASE, 8, lower clamp on accepted lease time in seconds.

Ports:
clock  in  1  system clock
reset  in  1  system reset
enable  in  1  level; client runs while high
dhcpoffer  in  1  one-cycle strobe from parser: valid OFFER received
dhcpacknowledge  in  1  one-cycle strobe from parser: valid ACK received
YIAddr  in  32  offered/assigned address, stable when strobe is high
SIAddr  in  32  server address, stable when strobe is high
ipleasetime  in  32  lease seconds, stable when strobe is high
tx_req  out  1  message request, held until tx_ack
tx_type  out  2  01 = DISCOVER, 11 = REQUEST; 00 when idle
tx_broadcast  out  1  1 = broadcast, 0 = unicast to req_serverid
req_ipaddr  out  32  requested IP (option 50 / ciaddr)
req_serverid  out  32  server identifier for REQUEST
tx_ack  in  1  one-cycle strobe from TX: message accepted
bound  out  1  high while holding a valid lease
my_ipaddr  out  32  leased address; 0 when not bound
lease_remaining  out  32  seconds left on lease; 0 when not bound
state_out  out  3  current state encoding
fail  out  1  one-cycle pulse when REQUEST retries are exhausted

Behaviour:
- Reset is asynchronous and active-high on reset; clock is clock.
- Reset values:
  - State = INIT.
  - All outputs 0.
  - Prescaler, retry timer, retry count and elapsed counter = 0.
- Prescaler:
  - Free-running counter 0..CLKS_PER_SEC-1.
  - sec_tick is high for one cycle on wrap; it runs in every state.
- State encoding: INIT=0, SELECTING=1, REQUESTING=2, BOUND=3, RENEWING=4, REBINDING=5.
- TX handshake:
  - On entry to a sending state, registered outputs assert the following in the same cycle: tx_req=1, tx_type, tx_broadcast, req_ipaddr, req_serverid.
  - These outputs remain stable until the cycle tx_ack=1, after which tx_req=0 and tx_type=00.
  - tx_ack while tx_req=0 is ignored.
  - While tx_req=1, offer/ack strobes are ignored and timers do not count.
- Retry timer:
  - Loaded with RETRY_SEC on tx_ack.
  - Decrements on sec_tick.
  - Expiry means the counter reaches 0 while no message is pending.
- INIT:
  - Bound is 0.
  - If enable: send DISCOVER (broadcast, req_ipaddr=0), then go to SELECTING.
- SELECTING:
  - On dhcpoffer: latch offered_ip=YIAddr and server_ip=SIAddr, go to REQUESTING, send REQUEST (broadcast, req_ipaddr=offered_ip, req_serverid=server_ip), retry count=0.
  - On retry expiry: resend DISCOVER, with no limit.
- REQUESTING:
  - On dhcpacknowledge: go to BOUND.
  - On expiry with retry count < MAX_RETRY: retry count+1 and resend REQUEST.
  - Otherwise: pulse fail and go to INIT.
- Entering BOUND from an ACK:
  - lease = max(ipleasetime, MIN_LEASE).
  - T1 = lease>>1.
  - T2 = lease - (lease>>3), computed in 32 bits.
  - Elapsed = 0, my_ipaddr = offered_ip, bound = 1.
- BOUND:
  - Elapsed increments on sec_tick.
  - When elapsed == T1: go to RENEWING and send REQUEST unicast (tx_broadcast=0, req_ipaddr=my_ipaddr).
- RENEWING:
  - On ACK: reload lease (same computation) and return to BOUND.
  - When elapsed == T2: go to REBINDING and send REQUEST broadcast.
  - No retry timer is used here.
- REBINDING:
  - On ACK: reload lease and return to BOUND.
  - When elapsed == lease: bound=0, my_ipaddr=0, go to INIT.
- lease_remaining = lease - elapsed while bound; otherwise 0.
- Infinite lease (ipleasetime == 32'hFFFFFFFF):
  - Elapsed never increments.
  - Stays in BOUND indefinitely, with lease_remaining = 32'hFFFFFFFF.
- Simultaneous events:
  - An ACK/offer strobe in the same cycle as a timer expiry or T1/T2/lease match: the strobe wins.
  - Strobes arriving in states that do not expect them are dropped (offer outside SELECTING; ACK in INIT, SELECTING or BOUND).
  - If offer and ack are both high in SELECTING, the offer is taken.
- enable low in any state:
  - Next cycle: INIT, with tx_req=0, bound=0, my_ipaddr=0 and timers cleared.
  - A pending tx is abandoned; fail is not pulsed.
- Reset mid-operation behaves identically to the reset values above.

Test Plan:
- Bench uses CLKS_PER_SEC=4, RETRY_SEC=2, MAX_RETRY=3.
- Normal flow:
  - enable=1 -> tx_req with tx_type=01 and tx_broadcast=1; tx_ack -> SELECTING.
  - dhcpoffer with YIAddr=C0A8010A, SIAddr=C0A80101 -> tx_type=11, req_ipaddr=C0A8010A, req_serverid=C0A80101.
  - tx_ack, then dhcpacknowledge with lease=16 -> bound=1, my_ipaddr=C0A8010A, lease_remaining=16, then decrementing every 4 cycles.
- Renew/rebind/expire with lease=16:
  - After 8 ticks: unicast REQUEST, state 4.
  - At 14 ticks: broadcast REQUEST, state 5.
  - At 16 ticks with no ACK: bound=0, state 0, then a new DISCOVER.
- Renew success: ACK with lease=40 in RENEWING -> state 3, lease_remaining=40, next renew at 20 ticks.
- Request exhaustion: no ACK after the offer -> 4 REQUESTs total spaced 2 s apart, then a fail pulse and a DISCOVER.
- Robustness:
  - enable dropped while tx_req=1 in REQUESTING -> tx_req=0 and state 0 the next cycle.
  - Stray dhcpacknowledge in SELECTING is ignored.
  - lease=3 clamps to 8.
  - lease=FFFFFFFF keeps bound permanently.
